// File: rtl/nyq_pkg.sv
// Shared types and defaults for the Nyquist decimation filter controller.
package nyq_pkg;

  localparam int MAX_DECIM = 8;
  localparam int PH_WIDTH  = 3;
  localparam int N_STAGES  = 4;
  localparam int DQ_WIDTH  = PH_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

  // A decimation code of zero selects the largest factor, which does not fit in PH_WIDTH bits.
  function automatic logic [DQ_WIDTH-1:0] decim_map(input logic [PH_WIDTH-1:0] decim);
    if (decim == '0) begin
      decim_map = DQ_WIDTH'(MAX_DECIM);
    end else begin
      decim_map = {1'b0, decim};
    end
  endfunction

endpackage

// File: rtl/nyq_ctrl_if.sv
// Control bus between the sample source / filter datapath and the sequencing controller.
interface nyq_ctrl_if
  import nyq_pkg::*;
#(
  parameter int PH_WIDTH = nyq_pkg::PH_WIDTH
);

  logic                En_SI;
  logic [PH_WIDTH-1:0] Decim_DI;
  logic                In_Valid_SI;
  logic [PH_WIDTH-1:0] Coef_Addr_DO;
  logic                Mac_En_SO;
  logic                Mac_Clr_SO;
  logic                Shift_En_SO;
  logic                Out_Valid_SO;
  logic                Busy_SO;

  // Sample source / datapath side.
  modport master (
    output En_SI, Decim_DI, In_Valid_SI,
    input  Coef_Addr_DO, Mac_En_SO, Mac_Clr_SO, Shift_En_SO, Out_Valid_SO, Busy_SO
  );

  // Controller side.
  modport slave (
    input  En_SI, Decim_DI, In_Valid_SI,
    output Coef_Addr_DO, Mac_En_SO, Mac_Clr_SO, Shift_En_SO, Out_Valid_SO, Busy_SO
  );

endinterface

// File: rtl/nyq_phase_cnt.sv
// Modulo-N phase counter with a wrap flag, reusable by any decimator.
module nyq_phase_cnt #(
  parameter int W = 3
) (
  input  logic         Clk_CI,
  input  logic         Rst_RBI,
  input  logic         Clr_SI,
  input  logic         Inc_SI,
  input  logic [W:0]   Mod_DI,
  output logic [W-1:0] Cnt_DO,
  output logic         Wrap_SO
);

  logic [W-1:0] cnt_q;
  logic         last_phase;

  assign last_phase = ({1'b0, cnt_q} == (Mod_DI - (W+1)'(1)));
  assign Wrap_SO    = Inc_SI & last_phase;
  assign Cnt_DO     = cnt_q;

  // Phase register: clear has priority, otherwise advance and wrap on each increment.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      cnt_q <= '0;
    end else if (Clr_SI) begin
      cnt_q <= '0;
    end else if (Inc_SI) begin
      cnt_q <= last_phase ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/nyq_ctrl.sv
// Sequencing controller for the polyphase Nyquist decimation filter.
module nyq_ctrl
  import nyq_pkg::*;
#(
  parameter int MAX_DECIM = nyq_pkg::MAX_DECIM,
  parameter int PH_WIDTH  = nyq_pkg::PH_WIDTH,
  parameter int N_STAGES  = nyq_pkg::N_STAGES
) (
  input  logic        Clk_CI,
  input  logic        Rst_RBI,
  nyq_ctrl_if.slave   bus
);

  localparam int SC_WIDTH = $clog2(N_STAGES) + 1;

  state_e              state_q, state_d;
  logic [PH_WIDTH:0]   d_q;
  logic [PH_WIDTH-1:0] phase;
  logic                wrap;
  logic                accept;
  logic                clr_phase;
  logic                shift_q;
  logic                ov_q;
  logic [SC_WIDTH-1:0] sc_q;
  logic [SC_WIDTH-1:0] sc_incl;
  logic                chain_full;

  assign accept    = bus.In_Valid_SI & (state_q != IDLE);
  // Dropping enable discards the partial frame immediately so IDLE always shows phase 0.
  assign clr_phase = ~bus.En_SI | (state_q == IDLE);

  // Shift count including a pulse emitted this cycle, saturating at the chain depth.
  assign sc_incl    = (shift_q && (sc_q < SC_WIDTH'(N_STAGES))) ? sc_q + SC_WIDTH'(1) : sc_q;
  assign chain_full = (sc_incl >= SC_WIDTH'(N_STAGES));

  nyq_phase_cnt #(
    .W (PH_WIDTH)
  ) u_phase_cnt (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .Clr_SI  (clr_phase),
    .Inc_SI  (accept),
    .Mod_DI  (d_q),
    .Cnt_DO  (phase),
    .Wrap_SO (wrap)
  );

  // State register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: warm-up ends once the partial-sum chain has been filled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.En_SI) state_d = WARMUP;
      WARMUP:  if (!bus.En_SI) state_d = IDLE;
               else if (shift_q && chain_full) state_d = RUN;
      RUN:     if (!bus.En_SI) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: MAC controls follow the incoming sample with no latency.
  always_comb begin
    bus.Mac_En_SO    = accept;
    bus.Mac_Clr_SO   = accept & (phase == '0);
    bus.Coef_Addr_DO = phase;
    bus.Shift_En_SO  = shift_q;
    bus.Out_Valid_SO = ov_q;
    bus.Busy_SO      = (state_q != IDLE);
  end

  // Decimation factor is captured only when leaving IDLE; later changes wait for re-enable.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      d_q <= (PH_WIDTH+1)'(MAX_DECIM);
    end else if ((state_q == IDLE) && bus.En_SI) begin
      d_q <= decim_map(bus.Decim_DI);
    end
  end

  // Shift counter: counts partial-sum captures since enable, cleared whenever idle.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      sc_q <= '0;
    end else if (!bus.En_SI || (state_q == IDLE)) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_incl;
    end
  end

  // Pulse registers: shift after the last phase, output-valid one cycle later once the chain is full.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      shift_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      shift_q <= wrap & bus.En_SI;
      ov_q    <= shift_q & chain_full & (state_q != IDLE) & bus.En_SI;
    end
  end

endmodule

// File: tb/tb_nyq_ctrl.sv
// Self-checking bench for nyq_ctrl against a sample-count based reference model.
module tb_nyq_ctrl;
  import nyq_pkg::*;

  logic Clk_CI = 1'b0;
  logic Rst_RBI;

  nyq_ctrl_if #(.PH_WIDTH(PH_WIDTH)) bus ();

  nyq_ctrl dut (
    .Clk_CI  (Clk_CI),
    .Rst_RBI (Rst_RBI),
    .bus     (bus)
  );

  always #5 Clk_CI = ~Clk_CI;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: everything follows from the number of samples accepted since enable.
  bit m_busy;
  bit m_sh;
  bit m_ov;
  int m_d;
  int m_n;

  task automatic model_reset();
    m_busy = 1'b0;
    m_sh   = 1'b0;
    m_ov   = 1'b0;
    m_d    = MAX_DECIM;
    m_n    = 0;
  endtask

  // Expected {addr, mac_en, mac_clr, shift_en, out_valid, busy} for the current cycle.
  function automatic logic [7:0] model_expect(input bit vld);
    bit me;
    int ph;
    me = vld && m_busy;
    ph = m_busy ? (m_n % m_d) : 0;
    return {3'(ph), me, me && (ph == 0), m_sh, m_ov, m_busy};
  endfunction

  task automatic model_advance(input bit en, input int dv, input bit vld);
    bit me, nsh, nov;
    me  = vld && m_busy;
    nsh = me && en && ((m_n % m_d) == m_d - 1);
    nov = m_sh && m_busy && en && ((m_n / m_d) >= N_STAGES);
    m_sh = nsh;
    m_ov = nov;
    if (!en) begin
      m_busy = 1'b0;
      m_n    = 0;
    end else if (!m_busy) begin
      m_busy = 1'b1;
      m_d    = (dv == 0) ? MAX_DECIM : dv;
      m_n    = 0;
    end else if (me) begin
      m_n = m_n + 1;
    end
  endtask

  function automatic logic [7:0] observed();
    return {bus.Coef_Addr_DO, bus.Mac_En_SO, bus.Mac_Clr_SO,
            bus.Shift_En_SO, bus.Out_Valid_SO, bus.Busy_SO};
  endfunction

  task automatic drive(input bit en, input int dv, input bit vld);
    logic [31:0] dvv;
    dvv = dv;
    @(negedge Clk_CI);
    bus.En_SI       = en;
    bus.Decim_DI    = dvv[2:0];
    bus.In_Valid_SI = vld;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    Rst_RBI         = 1'b0;
    bus.En_SI       = 1'b0;
    bus.Decim_DI    = '0;
    bus.In_Valid_SI = 1'b0;
    model_reset();
    #12;
    got = observed();
    vectors++;
    if (got !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_idle: got %b want %b", got, 8'h00);
    end
    bus.En_SI       = 1'b1;
    bus.In_Valid_SI = 1'b1;
    @(negedge Clk_CI);
    #1;
    got = observed();
    vectors++;
    if (got !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_held: got %b want %b", got, 8'h00);
    end
    bus.En_SI       = 1'b0;
    bus.In_Valid_SI = 1'b0;
    Rst_RBI         = 1'b1;
  endtask

  task automatic test_d8_continuous();
    logic [7:0] got, exp;
    int acc, first_ov;
    acc = 0;
    first_ov = -1;
    for (int i = 0; i < 84; i++) begin
      bit en;
      en = (i >= 2);
      drive(en, 0, 1'b1);
      exp = model_expect(1'b1);
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL d8_cont cyc %0d: got %b want %b", i, got, exp);
      end
      if (got[1] && first_ov < 0) first_ov = acc;
      if (got[4]) acc++;
      model_advance(en, 0, 1'b1);
    end
    vectors++;
    if (first_ov !== 33) begin
      miscompares++;
      $display("FAIL d8_first_ov: samples before first strobe %0d want 33", first_ov);
    end
  endtask

  task automatic test_d3_alternate();
    logic [7:0] got, exp;
    for (int i = 0; i < 64; i++) begin
      bit en, vld;
      en  = (i >= 2);
      vld = (i % 2 == 1);
      drive(en, 3, vld);
      exp = model_expect(vld);
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL d3_alt cyc %0d: got %b want %b", i, got, exp);
      end
      model_advance(en, 3, vld);
    end
  endtask

  task automatic test_d1();
    logic [7:0] got, exp;
    for (int i = 0; i < 24; i++) begin
      bit en;
      en = (i >= 2);
      drive(en, 1, 1'b1);
      exp = model_expect(1'b1);
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL d1_cont cyc %0d: got %b want %b", i, got, exp);
      end
      model_advance(en, 1, 1'b1);
    end
  endtask

  task automatic test_en_drop();
    logic [7:0] got, exp;
    for (int i = 0; i < 64; i++) begin
      bit en, vld;
      en  = (i >= 2 && i < 8) || (i >= 11);
      vld = en;
      drive(en, 0, vld);
      exp = model_expect(vld);
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL en_drop cyc %0d: got %b want %b", i, got, exp);
      end
      model_advance(en, 0, vld);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] got, exp;
    for (int i = 0; i < 45; i++) begin
      drive(1'b1, 0, 1'b1);
      exp = model_expect(1'b1);
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL pre_rst cyc %0d: got %b want %b", i, got, exp);
      end
      model_advance(1'b1, 0, 1'b1);
    end
    @(negedge Clk_CI);
    #3;
    Rst_RBI = 1'b0;
    #1;
    got = observed();
    vectors++;
    if (got !== 8'h00) begin
      miscompares++;
      $display("FAIL async_rst: got %b want %b", got, 8'h00);
    end
    model_reset();
    @(negedge Clk_CI);
    bus.En_SI       = 1'b0;
    bus.In_Valid_SI = 1'b0;
    Rst_RBI         = 1'b1;
    test_d8_continuous();
  endtask

  task automatic test_decim_change();
    logic [7:0] got, exp;
    for (int i = 0; i < 110; i++) begin
      bit en;
      int dv;
      en = (i >= 2 && i < 74) || (i >= 76);
      dv = (i < 42) ? 0 : 2;
      drive(en, dv, 1'b1);
      exp = model_expect(1'b1);
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL decim_chg cyc %0d: got %b want %b", i, got, exp);
      end
      model_advance(en, dv, 1'b1);
    end
  endtask

  task automatic test_random();
    logic [7:0] got, exp;
    bit en;
    int dv;
    en = 1'b0;
    dv = 0;
    for (int i = 0; i < 600; i++) begin
      bit vld;
      if ($urandom_range(0, 99) < 4) en = ~en;
      if (!en && $urandom_range(0, 99) < 50) en = 1'b1;
      if ($urandom_range(0, 99) < 10) dv = $urandom_range(0, 7);
      vld = ($urandom_range(0, 99) < 70);
      drive(en, dv, vld);
      exp = model_expect(vld);
      got = observed();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random cyc %0d: got %b want %b", i, got, exp);
      end
      model_advance(en, dv, vld);
    end
  endtask

  initial begin
    test_reset();
    test_d8_continuous();
    test_d3_alternate();
    test_d1();
    test_en_drop();
    test_async_reset();
    test_decim_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nyq_ctrl.md
# nyq_ctrl

Sequencing controller for the polyphase Nyquist decimation filter. Tracks the input-sample phase and drives the coefficient address, MAC clear and enable, partial-sum register enable and output-valid strobe. It sits between the sample source and the four-MAC transposed filter datapath. It suppresses output-valid until the partial-sum chain has filled after enable.

## Interface
- MAX_DECIM, 8: maximum decimation factor, equal to the number of phases per filter stage.
- PH_WIDTH, 3: phase and coefficient-address width; must equal clog2(MAX_DECIM).
- N_STAGES, 4: number of MAC and partial-sum stages in the datapath.
- Clk_CI  in  1  clock.
- Rst_RBI  in  1  reset, asynchronous, active low.
- En_SI  in  1  filter enable, level-sensitive.
- Decim_DI  in  PH_WIDTH  decimation factor. Values 1..MAX_DECIM-1 are literal; 0 means MAX_DECIM. Latched on the IDLE exit.
- In_Valid_SI  in  1  a new input sample is present this cycle.
- Coef_Addr_DO  out  PH_WIDTH  current phase; the datapath uses it as the coefficient base address.
- Mac_En_SO  out  1  MACs accumulate this cycle.
- Mac_Clr_SO  out  1  MACs load the product instead of accumulating; this is the first phase of a frame.
- Shift_En_SO  out  1  partial-sum registers capture the MAC outputs.
- Out_Valid_SO  out  1  the filter output is valid; single-cycle strobe.
- Busy_SO  out  1  state is not IDLE.

## Operation
- FSM states:
  - IDLE: held while En_SI=0. Phase=0, shift count=0, all pulse outputs 0.
  - IDLE→WARMUP when En_SI=1. Decim_DI is latched into D_q in the same cycle.
  - WARMUP→RUN on the N_STAGES-th Shift_En_SO.
  - RUN stays in RUN.
  - Any state→IDLE in the cycle after En_SI=0.
- Phase counter:
  - Increments on every accepted sample, i.e. In_Valid_SI=1 in WARMUP or RUN.
  - Wraps from D_q-1 to 0.
  - With D_q=1 the phase stays 0, and every sample is both the first and the last phase.
- Combinational outputs:
  - Mac_En_SO = In_Valid_SI & (state≠IDLE).
  - Mac_Clr_SO = Mac_En_SO & (phase==0).
  - Coef_Addr_DO = phase register.
- Shift_En_SO is registered. It is 1 in the cycle after a sample accepted at phase D_q-1; otherwise 0.
- Shift counter:
  - Saturates at N_STAGES and counts Shift_En_SO pulses.
  - Width is clog2(N_STAGES)+1.
- Out_Valid_SO is registered. It is 1 in the cycle after Shift_En_SO whenever the shift count, including that pulse, is ≥ N_STAGES. This means no strobe for the first N_STAGES-1 frames.
- Simultaneous events:
  - A sample arriving in the same cycle as Shift_En_SO is legal and needs no stall. It is phase 0, so Mac_Clr_SO=1.
  - At that edge the partial-sum registers capture the completed sums while the MACs load the new product.
- En_SI deasserted mid-frame:
  - Cancels the frame and discards the partial phase count.
  - A Shift_En_SO or Out_Valid_SO already registered still emits in the next cycle.
  - After that no new pulses are generated, and state is IDLE.
- Decim_DI changes outside IDLE are ignored until the next enable.

## Timing
- Reset values: Coef_Addr_DO=0, Mac_En_SO=0, Mac_Clr_SO=0, Shift_En_SO=0, Out_Valid_SO=0, Busy_SO=0, state=IDLE, D_q=MAX_DECIM.
- Latency from the last-phase sample to the edges:
  - to Shift_En_SO: 1 cycle;
  - to Out_Valid_SO: 2 cycles.
- Mac_En_SO, Mac_Clr_SO and Coef_Addr_DO have 0 latency: they are valid in the same cycle as In_Valid_SI.
- Busy_SO is asserted the cycle after En_SI rises. Samples in that rising cycle are ignored because state is still IDLE.
- Maximum throughput is one sample per cycle with no back-pressure.

## Structure
- Shared package nyq_pkg contains:
  - the state enum: IDLE, WARMUP, RUN;
  - the MAX_DECIM, PH_WIDTH and N_STAGES defaults;
  - a function mapping Decim_DI=0 to MAX_DECIM.
- One natural sub-module: nyq_phase_cnt. It is the modulo-D_q counter with a wrap flag and is reusable for other decimators.
- The FSM, shift counter and pulse registers live in nyq_ctrl.

## Test plan
1. Reset, then En_SI=1 with Decim_DI=0 and continuous In_Valid_SI.
   - Coef_Addr_DO cycles 0..7.
   - Mac_Clr_SO asserts on every sample with Coef_Addr_DO=0.
   - Shift_En_SO pulses every 8 cycles.
   - The first Out_Valid_SO comes after the 4th Shift_En_SO: 2 cycles after the 32nd sample.
2. Decim_DI=3 with In_Valid_SI every other cycle.
   - Phases run 0,1,2,0.
   - Shift_En_SO comes 1 cycle after each phase-2 sample.
   - Out_Valid_SO comes 2 cycles after the 12th sample, then once every 3 samples.
3. Decim_DI=1 with continuous valid.
   - Mac_Clr_SO and Mac_En_SO stay high.
   - Shift_En_SO is high from the second cycle on.
   - Out_Valid_SO first asserts 2 cycles after the 4th sample.
4. En_SI drops after 5 samples of a D=8 frame.
   - Busy_SO=0 next cycle and no Shift_En_SO follows.
   - Re-enabling restarts at phase 0 with the full 4-frame warm-up.
5. Rst_RBI asserted mid-RUN, asynchronously between clock edges.
   - All outputs are 0 immediately and D_q=8.
   - Operation after release matches scenario 1.
6. Decim_DI changed from 8 to 2 while in RUN.
   - The period stays 8.
   - It takes effect only after En_SI toggles low then high.
